// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : MEM stage of the pipeline. Waits for the data-SRAM response on
//            memory ops, aligns/extends load data and hands results to WB
//            under valid/allow_in flow control; exports a forwarding bus to ID.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int EX_TO_MEM_W = 75,
  parameter int MEM_TO_WB_W = 70,
  parameter int MEM_TO_ID_W = 40
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   ex_to_mem_valid,
  output logic                   mem_allow_in,
  input  logic [EX_TO_MEM_W-1:0] ex_to_mem_bus,
  input  logic                   data_sram_data_ok,
  input  logic [31:0]            data_sram_rdata,
  input  logic                   wb_allow_in,
  output logic                   mem_to_wb_valid,
  output logic [MEM_TO_WB_W-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_W-1:0] mem_to_id_bus
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;

  logic [1:0]             state_q, state_d;
  logic                   mem_valid_q, mem_valid_d;
  logic                   buf_valid_q, buf_valid_d;
  logic [31:0]            buf_q, buf_d;
  logic [EX_TO_MEM_W-1:0] bus_q, bus_d;

  // Fields of the instruction currently held in MEM
  logic [31:0] w_pc;
  logic [31:0] w_alu_result;
  logic        w_mem_req;
  logic        w_res_from_mem;
  logic [1:0]  w_mem_size;
  logic        w_mem_unsigned;
  logic        w_reg_we;
  logic [4:0]  w_reg_waddr;
  logic        w_in_mem_req;

  logic        w_ok_in_wait;
  logic        w_ready_go;
  logic        w_allow_in;
  logic        w_capture;

  logic [31:0] w_src;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_final_result;
  logic        w_load_pending;

  assign w_pc           = bus_q[74:43];
  assign w_alu_result   = bus_q[42:11];
  assign w_mem_req      = bus_q[10];
  assign w_res_from_mem = bus_q[9];
  assign w_mem_size     = bus_q[8:7];
  assign w_mem_unsigned = bus_q[6];
  assign w_reg_we       = bus_q[5];
  assign w_reg_waddr    = bus_q[4:0];
  assign w_in_mem_req   = ex_to_mem_bus[10];

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------- handshake logic
  // data_ok only counts while a request is outstanding; strays are dropped.
  always_comb begin
    w_ok_in_wait = (state_q == S_WAIT) && data_sram_data_ok;
    w_ready_go   = !w_mem_req || buf_valid_q || w_ok_in_wait;
    w_allow_in   = !mem_valid_q || (w_ready_go && wb_allow_in);
    w_capture    = w_ok_in_wait && !w_allow_in;
  end

  // ---------------------------------------------------------- next-state comb
  always_comb begin
    state_d = state_q;
    if (w_allow_in) begin
      if (!ex_to_mem_valid) begin
        state_d = S_EMPTY;
      end else if (w_in_mem_req) begin
        state_d = S_WAIT;
      end else begin
        state_d = S_RUN;
      end
    end else if (w_capture) begin
      state_d = S_DONE;
    end
  end

  // ------------------------------------------------------------- output comb
  always_comb begin
    mem_allow_in    = w_allow_in;
    mem_to_wb_valid = mem_valid_q && w_ready_go;
    w_load_pending  = mem_valid_q && w_res_from_mem && !w_ready_go;
  end

  // ------------------------------------------------------------ datapath regs
  always_comb begin
    mem_valid_d = mem_valid_q;
    bus_d       = bus_q;
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    if (w_allow_in) begin
      mem_valid_d = ex_to_mem_valid;
      buf_valid_d = 1'b0;
      if (ex_to_mem_valid) begin
        bus_d = ex_to_mem_bus;
      end
    end else if (w_capture) begin
      // WB is stalled: hold the response until it can be handed off
      buf_valid_d = 1'b1;
      buf_d       = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_q       <= 32'd0;
      bus_q       <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      bus_q       <= bus_d;
    end
  end

  // ------------------------------------------------------ load align / extend
  always_comb begin
    w_src = buf_valid_q ? buf_q : data_sram_rdata;
    case (w_alu_result[1:0])
      2'd0:    w_byte = w_src[7:0];
      2'd1:    w_byte = w_src[15:8];
      2'd2:    w_byte = w_src[23:16];
      default: w_byte = w_src[31:24];
    endcase
    w_half = w_alu_result[1] ? w_src[31:16] : w_src[15:0];
    case (w_mem_size)
      SZ_B:    w_load_data = {{24{!w_mem_unsigned && w_byte[7]}}, w_byte};
      SZ_H:    w_load_data = {{16{!w_mem_unsigned && w_half[15]}}, w_half};
      default: w_load_data = w_src;
    endcase
    w_final_result = w_res_from_mem ? w_load_data : w_alu_result;
  end

  assign mem_to_wb_bus = {w_pc, w_final_result, w_reg_we, w_reg_waddr};
  assign mem_to_id_bus = {mem_valid_q, w_reg_we, w_reg_waddr, w_final_result, w_load_pending};

  // A response with nothing outstanding indicates a broken upstream protocol
  a_data_ok_in_wait : assert property (@(posedge clk) disable iff (!resetn)
    data_sram_data_ok |-> (state_q == S_WAIT))
    else $warning("mem_stage: data_ok outside WAIT ignored");

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Randomized scoreboard bench for mem_stage with directed cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        ex_to_mem_valid;
  logic        mem_allow_in;
  logic [74:0] ex_to_mem_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_allow_in;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_bus;
  logic [39:0] mem_to_id_bus;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ex_to_mem_valid   (ex_to_mem_valid),
    .mem_allow_in      (mem_allow_in),
    .ex_to_mem_bus     (ex_to_mem_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .wb_allow_in       (wb_allow_in),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .mem_to_id_bus     (mem_to_id_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        mem_req;
    logic        res_mem;
    logic [1:0]  size;
    logic        uns;
    logic        we;
    logic [4:0]  wa;
    int          delay;
    int          stall;
    bit          stray;
  } instr_t;

  typedef struct {
    logic [69:0] bus;
    bit          is_load;
    bit          done;
  } exp_t;

  instr_t stim_q[$];
  exp_t   sb_q[$];

  int checks = 0;
  int errors = 0;

  bit          drv_en = 0;
  bit          mon_en = 0;
  bit          acc_pending = 0;
  instr_t      acc_i;
  bit          resp_active = 0;
  int          resp_cnt = 0;
  int          resp_stall = 0;
  logic [31:0] resp_data;
  int          stall_cnt = 0;
  bit          stray_now = 0;
  int          wb_pct = 100;
  int          valid_pct = 100;

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout at %0t", nm, $time);
  endtask

  // Reference result: pick the addressed byte/half and extend, or pass alu through
  function automatic logic [69:0] model(input instr_t i);
    logic [31:0] res;
    logic [7:0]  b;
    logic [15:0] h;
    int          off;
    off = int'(i.alu[1:0]);
    b   = 8'(i.rdata >> (8 * off));
    h   = 16'(i.rdata >> (16 * (off / 2)));
    res = i.alu;
    if (i.res_mem) begin
      if (i.size == 2'd0)      res = i.uns ? 32'(b) : 32'($signed(b));
      else if (i.size == 2'd1) res = i.uns ? 32'(h) : 32'($signed(h));
      else                     res = i.rdata;
    end
    return {i.pc, res, i.we, i.wa};
  endfunction

  function automatic instr_t mk(input logic [31:0] pc, input logic [31:0] alu,
                                input logic mreq, input logic rmem, input logic [1:0] sz,
                                input logic uns, input logic we, input logic [4:0] wa,
                                input logic [31:0] rd, input int dly, input int stl,
                                input bit stray);
    instr_t r;
    r.pc = pc; r.alu = alu; r.mem_req = mreq; r.res_mem = rmem; r.size = sz;
    r.uns = uns; r.we = we; r.wa = wa; r.rdata = rd; r.delay = dly; r.stall = stl;
    r.stray = stray;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    int     kind;
    kind = $urandom_range(0, 2);
    r = mk($urandom & 32'hFFFF_FFFC, $urandom, 1'b0, 1'b0, 2'($urandom_range(0, 2)),
           1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 1'b0);
    if (kind == 1) begin
      r.mem_req = 1'b1;
      r.res_mem = 1'b1;
    end else if (kind == 2) begin
      r.mem_req = 1'b1;
    end
    if (r.size == 2'd1) r.alu[0] = 1'b0;
    if (r.size == 2'd2) r.alu[1:0] = 2'b00;
    return r;
  endfunction

  // Driver: presents EX instructions, plays the SRAM responder and WB stalls
  always begin : driver
    @(posedge clk);
    if (drv_en) begin
      stray_now = 1'b0;
      if (acc_pending) begin
        acc_pending = 1'b0;
        sb_q.push_back('{bus: model(acc_i), is_load: acc_i.res_mem, done: !acc_i.mem_req});
        if (acc_i.mem_req) begin
          resp_active = 1'b1;
          resp_cnt    = acc_i.delay;
          resp_data   = acc_i.rdata;
          resp_stall  = acc_i.stall;
        end else begin
          stall_cnt = acc_i.stall;
          stray_now = acc_i.stray;
        end
        void'(stim_q.pop_front());
      end
      #1;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = $urandom;
      if (resp_active) begin
        if (resp_cnt == 0) begin
          data_sram_data_ok = 1'b1;
          data_sram_rdata   = resp_data;
          resp_active       = 1'b0;
          sb_q[0].done      = 1'b1;
          stall_cnt         = resp_stall;
        end else begin
          resp_cnt--;
        end
      end
      if (stray_now) data_sram_data_ok = 1'b1;
      wb_allow_in = (stall_cnt > 0) ? 1'b0 : ($urandom_range(0, 99) < wb_pct);
      if (stall_cnt > 0) stall_cnt--;
      if (stim_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = {stim_q[0].pc, stim_q[0].alu, stim_q[0].mem_req, stim_q[0].res_mem,
                           stim_q[0].size, stim_q[0].uns, stim_q[0].we, stim_q[0].wa};
      end else begin
        ex_to_mem_valid = 1'b0;
        ex_to_mem_bus   = {$urandom, $urandom, 11'($urandom)};
      end
      @(negedge clk);
      if (ex_to_mem_valid && mem_allow_in) begin
        acc_pending = 1'b1;
        acc_i       = stim_q[0];
      end
    end
  end

  // Monitor: compares every presented output against the scoreboard head
  always @(negedge clk) begin : monitor
    bit have;
    bit exp_v;
    bit exp_lp;
    if (mon_en) begin
      have   = sb_q.size() > 0;
      exp_v  = have && sb_q[0].done;
      exp_lp = have && sb_q[0].is_load && !sb_q[0].done;
      chk("wb_valid", 70'(mem_to_wb_valid), 70'(exp_v));
      chk("mem_allow_in", 70'(mem_allow_in), 70'(!have || (exp_v && wb_allow_in)));
      chk("fwd_valid", 70'(mem_to_id_bus[39]), 70'(have));
      chk("load_pending", 70'(mem_to_id_bus[0]), 70'(exp_lp));
      if (exp_v) begin
        chk("wb_bus", mem_to_wb_bus, sb_q[0].bus);
        chk("fwd_bus", 70'(mem_to_id_bus[38:1]), 70'({sb_q[0].bus[5:0], sb_q[0].bus[37:6]}));
        if (wb_allow_in) void'(sb_q.pop_front());
      end
    end
  end

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while ((stim_q.size() > 0 || sb_q.size() > 0 || acc_pending) && n < budget);
    if (n >= budget) timeout_fail(nm);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_wb_valid"}, 70'(mem_to_wb_valid), 70'(0));
    chk({nm, "_allow_in"}, 70'(mem_allow_in), 70'(1));
    chk({nm, "_id_bus"}, 70'(mem_to_id_bus), 70'(0));
    chk({nm, "_wb_bus"}, mem_to_wb_bus, 70'(0));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    resetn            = 1'b0;
    ex_to_mem_valid   = 1'b0;
    ex_to_mem_bus     = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    wb_allow_in       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    resetn = 1'b1;
    drv_en = 1'b1;
    mon_en = 1'b1;

    // Back-to-back ALU ops at full rate
    stim_q.push_back(mk(32'h1c00_0000, 32'h1234_5678, 0, 0, 2'd2, 0, 1, 5'd5, 0, 0, 0, 0));
    for (int i = 1; i < 4; i++)
      stim_q.push_back(mk(32'h1c00_0000 + 32'(4 * i), $urandom, 0, 0, 2'd2, 0, 1, 5'(i), 0, 0, 0, 0));
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while ((stim_q.size() > 0 || sb_q.size() > 0 || acc_pending) && n < 50);
    chk("b2b_cycles", 70'(n <= 6), 70'(1));

    // ld.b off=3, sign-extended 0x80
    stim_q.push_back(mk(32'h1c00_0010, 32'h0000_1003, 1, 1, 2'd0, 0, 1, 5'd7, 32'h80AA_BBCC, 2, 0, 0));
    // ld.hu off=2 with WB stalled after the response
    stim_q.push_back(mk(32'h1c00_0014, 32'h0000_2002, 1, 1, 2'd1, 1, 1, 5'd8, 32'hBEEF_1234, 0, 4, 0));
    // st.w, no register write
    stim_q.push_back(mk(32'h1c00_0018, 32'h0000_3000, 1, 0, 2'd2, 0, 0, 5'd0, 32'h0, 3, 0, 0));
    // stray data_ok while an ALU op sits in RUN
    stim_q.push_back(mk(32'h1c00_001c, 32'hCAFE_F00D, 0, 0, 2'd2, 0, 1, 5'd9, 0, 0, 2, 1));
    stim_q.push_back(mk(32'h1c00_0020, 32'h0000_4001, 1, 1, 2'd0, 1, 1, 5'd10, 32'h1234_56F7, 1, 0, 0));
    wait_idle(200, "directed_idle");

    // Reset while a load is waiting for its response
    stim_q.push_back(mk(32'h1c00_0024, 32'h0000_5000, 1, 1, 2'd2, 0, 1, 5'd11, 32'h5555_AAAA, 20, 0, 0));
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (sb_q.size() == 0 && n < 20);
    if (n >= 20) timeout_fail("reset_wait_entry");
    @(negedge clk);
    #1;
    drv_en            = 1'b0;
    mon_en            = 1'b0;
    ex_to_mem_valid   = 1'b0;
    data_sram_data_ok = 1'b0;
    wb_allow_in       = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    stim_q.delete();
    sb_q.delete();
    acc_pending = 1'b0;
    resp_active = 1'b0;
    stall_cnt   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_wb_valid", 70'(mem_to_wb_valid), 70'(0));
      chk("post_rst_allow_in", 70'(mem_allow_in), 70'(1));
      chk("post_rst_id_bus", 70'(mem_to_id_bus), 70'(0));
      @(posedge clk);
      #1;
      data_sram_data_ok = 1'b0;
    end
    drv_en = 1'b1;
    mon_en = 1'b1;

    // Randomized traffic with WB and EX bubbles
    wb_pct    = 70;
    valid_pct = 80;
    for (int i = 0; i < 300; i++) stim_q.push_back(rand_instr());
    wait_idle(6000, "random_idle");

    @(negedge clk);
    mon_en = 1'b0;
    drv_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
